imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl_pkg.sv | 15 +
 rtl/imem_fetch_ctrl_fifo.sv | 78 +++++++
 rtl/imem_fetch_ctrl.sv | 95 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the fetch FSM state type, the per-fetch PC increment, the default
// reset PC and the width of one prefetch buffer entry ({pc, instr}).
package imem_fetch_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    localparam logic [63:0] PC_INC           = 64'd4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;
    localparam int unsigned ENTRY_W          = 96;

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: small registered FIFO used as the fetch prefetch buffer.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   push, wdata   - write request and data (ignored when full without a pop)
//   pop           - remove head (ignored when empty)
//   flush         - empty the buffer; wins over push/pop
//   rdata         - head entry, read straight from registered storage
//   full, empty, count - occupancy status
module fetch_fifo
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW-1:0]    wptr_nxt, rptr_nxt;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];

    assign do_pop  = pop && !empty;
    // A full buffer can still accept a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_nxt = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        rptr_nxt = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Storage is cleared too so the head reads zero during reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_nxt;
            end
            if (do_pop) begin
                rptr_q <= rptr_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequential instruction fetch into a prefetch buffer.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   en                          - fetch enable (IDLE/RUN)
//   redirect_valid, redirect_pc - flush buffer and restart fetch at redirect_pc
//   imem_addr, imem_q           - word address to / data from combinational ROM
//   out_valid, out_instr, out_pc, out_ready - head of prefetch buffer
//   align_err                   - sticky misaligned-redirect flag
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned AW       = 6,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          redirect_valid,
    input  logic [63:0]   redirect_pc,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_q,
    output logic          out_valid,
    output logic [31:0]   out_instr,
    output logic [63:0]   out_pc,
    input  logic          out_ready,
    output logic          align_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e         state_q, state_d;
    logic [63:0]          fetch_pc_q, fetch_pc_d;
    logic                 align_err_q, align_err_d;
    logic                 fifo_full, fifo_empty, pop, enq;
    logic [CW-1:0]        fifo_count;
    logic [ENTRY_W-1:0]   fifo_rdata;

    assign imem_addr = fetch_pc_q[AW+1:2];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_ready && !fifo_empty;
    // Redirect beats enqueue; a full buffer only accepts when the head leaves.
    assign enq       = (state_q == RUN) && !redirect_valid && (!fifo_full || pop);
    assign out_pc    = fifo_rdata[95:32];
    assign out_instr = fifo_rdata[31:0];
    assign align_err = align_err_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        align_err_d = align_err_q;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                align_err_d = 1'b1;
            end
        end else if (enq) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            align_err_q <= align_err_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (enq),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({fetch_pc_q, imem_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: expected PC stream held in a
// scoreboard queue, refilled on reset release and on each redirect.
module tb_imem_fetch_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 6;

    logic          clk;
    logic          reset;
    logic          en;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [63:0]   out_pc;
    logic          out_ready;
    logic          align_err;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    int          pops_before;
    logic [63:0] exp_q [$];

    imem_fetch_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .align_err      (align_err)
    );

    // ROM word i = A000_0000 + i
    assign imem_q = 32'hA000_0000 + {{(32 - AW){1'b0}}, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] pc);
        return 32'hA000_0000 + {{(32 - AW){1'b0}}, pc[AW+1:2]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic refill(input logic [63:0] pc);
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(pc + 64'(4 * i));
        end
    endtask

    // One clock: score an accepted head at the negedge, then take the edge.
    task automatic tick();
        logic        rd;
        logic [63:0] rpc;
        logic [63:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_pc", out_pc, e);
                check_eq("out_instr", {32'h0, out_instr}, {32'h0, rom_word(e)});
                pops++;
            end
        end
        rd  = redirect_valid;
        rpc = redirect_pc;
        @(posedge clk);
        #1;
        if (rd) refill({rpc[63:2], 2'b00});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        refill(64'h0);
        pops = 0;
    endtask

    initial begin
        reset          = 1'b1;
        en             = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #12;
        check_eq("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check_eq("rst_out_pc", out_pc, 64'h0);
        check_eq("rst_out_instr", {32'h0, out_instr}, 64'h0);
        check_eq("rst_align_err", {63'h0, align_err}, 64'h0);
        check_eq("rst_imem_addr", 64'(imem_addr), 64'h0);

        // Streaming from reset PC
        en        = 1'b1;
        out_ready = 1'b1;
        do_reset();
        repeat (12) tick();
        check_eq("stream_pops", 64'(pops >= 9), 64'd1);

        // Saturation with consumer stalled
        out_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        check_eq("sat_valid", {63'h0, out_valid}, 64'h1);
        check_eq("sat_imem_addr", 64'(imem_addr), 64'(DEPTH));
        out_ready = 1'b1;
        repeat (8) tick();
        check_eq("sat_drain_pops", 64'(pops >= 6), 64'd1);

        // Redirect with simultaneous pop of a full buffer
        out_ready = 1'b0;
        repeat (4) tick();
        check_eq("full_valid", {63'h0, out_valid}, 64'h1);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        pops_before    = pops;
        tick();
        redirect_valid = 1'b0;
        check_eq("redir_head_popped", 64'(pops - pops_before), 64'd1);
        check_eq("redir_empty", {63'h0, out_valid}, 64'h0);
        check_eq("redir_imem_addr", 64'(imem_addr), 64'd16);
        pops_before = pops;
        repeat (4) tick();
        check_eq("redir_pops", 64'(pops > pops_before), 64'd1);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFC;
        tick();
        redirect_valid = 1'b0;
        check_eq("wrap_addr_63", 64'(imem_addr), 64'd63);
        tick();
        check_eq("wrap_addr_0", 64'(imem_addr), 64'd0);
        pops_before = pops;
        repeat (4) tick();
        check_eq("wrap_pops", 64'(pops - pops_before >= 2), 64'd1);

        // Misaligned redirect, sticky flag
        check_eq("align_pre", {63'h0, align_err}, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h22;
        tick();
        redirect_valid = 1'b0;
        check_eq("align_set", {63'h0, align_err}, 64'h1);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        tick();
        redirect_valid = 1'b0;
        check_eq("align_sticky", {63'h0, align_err}, 64'h1);
        repeat (3) tick();

        // Asynchronous reset with buffered entries
        out_ready = 1'b0;
        do_reset();
        check_eq("align_cleared", {63'h0, align_err}, 64'h0);
        repeat (3) tick();
        check_eq("pre_async_valid", {63'h0, out_valid}, 64'h1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_valid", {63'h0, out_valid}, 64'h0);
        check_eq("async_out_pc", out_pc, 64'h0);
        check_eq("async_out_instr", {32'h0, out_instr}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        refill(64'h0);
        pops      = 0;
        out_ready = 1'b1;
        repeat (6) tick();
        check_eq("restart_pops", 64'(pops >= 3), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
